sys_array_feeder: RTL and testbench

Upstream input stage for sys_array_basic. It accepts one unskewed input vector per cycle over a valid/ready handshake. It produces the diagonally skewed stream the array needs: lane j is delayed j cycles relative to lane 0, and inactive lanes are forced to zero. It also tracks burst boundaries and signals when the final element of a burst has entered the array.

---
 rtl/sys_array_pkg.sv | 19 +
 rtl/sys_array_skew_lane.sv | 46 ++++
 rtl/sys_array_feeder.sv | 107 ++++++++++
 tb/tb_sys_array_feeder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_array_pkg.sv
// Shared types and helpers for the systolic-array front end.
package sys_array_pkg;

   localparam int DATA_WIDTH_DEF = 8;

   typedef logic [DATA_WIDTH_DEF-1:0] data_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } feeder_state_t;

   // Lane-count field width; a single lane still needs one bit.
   function automatic int lw_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sys_array_skew_lane.sv
// One skew lane: a DEPTH-stage data+valid delay line that carries zeros in invalid slots.
module sys_array_skew_lane #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH-1:0]      vld_q;
   logic [DEPTH-1:0]      vld_d;

   always_comb begin
      // Invalid slots enter as exact zeros so stale or unknown input never propagates.
      data_d[0] = in_valid ? in_data : '0;
      vld_d[0]  = in_valid;
      for (int i = 1; i < DEPTH; i++) begin
         data_d[i] = data_q[i-1];
         vld_d[i]  = vld_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
         end
         vld_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= data_d[i];
         end
         vld_q <= vld_d;
      end
   end

   assign out_valid = vld_q[DEPTH-1];
   assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/sys_array_feeder.sv
// Input stage for the systolic array: accepts unskewed vectors and emits the diagonally
// skewed, lane-gated stream, with burst tracking and an end-of-burst done pulse.
module sys_array_feeder
   import sys_array_pkg::*;
#(
   parameter int  DATA_WIDTH  = 8,
   parameter int  ARRAY_MAX_L = 10,
   localparam int LW          = lw_of(ARRAY_MAX_L)
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  logic [LW-1:0]                          array_w_l,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [0:ARRAY_MAX_L-1][DATA_WIDTH-1:0] in_data,
   input  logic                                   in_last,
   output logic [0:ARRAY_MAX_L-1][DATA_WIDTH-1:0] input_data,
   output logic [0:ARRAY_MAX_L-1]                 lane_valid,
   output logic                                   busy,
   output logic                                   done
);

   localparam logic [LW-1:0] W_MAX = LW'(ARRAY_MAX_L - 1);

   feeder_state_t state_q, state_d;
   logic [LW-1:0] w_l_q, w_l_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;
   logic [LW-1:0] w_clamp;
   logic [LW-1:0] w_sel;
   logic          accept;

   assign in_ready = (state_q != DRAIN);
   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign accept   = in_valid && in_ready;
   assign w_clamp  = (array_w_l > W_MAX) ? W_MAX : array_w_l;
   // The first vector of a burst is gated by the width being latched on the same edge.
   assign w_sel    = (state_q == IDLE) ? w_clamp : w_l_q;

   always_comb begin
      state_d = state_q;
      w_l_d   = w_l_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               w_l_d = w_clamp;
               if (in_last) begin
                  state_d = DRAIN;
                  cnt_d   = w_clamp;
               end else begin
                  state_d = STREAM;
               end
            end
         end
         STREAM: begin
            if (accept && in_last) begin
               state_d = DRAIN;
               cnt_d   = w_l_q;
            end
         end
         DRAIN: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Counter reaches zero exactly when the last vector's element w_l is on its lane.
      done_d = (state_d == DRAIN) && (cnt_d == '0);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         w_l_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         w_l_q   <= w_l_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   for (genvar j = 0; j < ARRAY_MAX_L; j++) begin : g_lane
      logic lane_in_vld;
      assign lane_in_vld = accept && (LW'(j) <= w_sel);

      sys_array_skew_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (j + 1)
      ) u_lane (
         .clk       (clk),
         .reset_n   (reset_n),
         .in_valid  (lane_in_vld),
         .in_data   (in_data[j]),
         .out_valid (lane_valid[j]),
         .out_data  (input_data[j])
      );
   end

endmodule

// File: tb/tb_sys_array_feeder.sv
// Bench for sys_array_feeder: directed and random bursts against a schedule-based reference.
module tb_sys_array_feeder;

   localparam int W    = 8;
   localparam int L    = 10;
   localparam int LW   = 4;
   localparam int MAXC = 4096;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic [LW-1:0]        array_w_l;
   logic                 in_valid;
   logic                 in_ready;
   logic [0:L-1][W-1:0]  in_data;
   logic                 in_last;
   logic [0:L-1][W-1:0]  input_data;
   logic [0:L-1]         lane_valid;
   logic                 busy;
   logic                 done;

   sys_array_feeder #(
      .DATA_WIDTH  (W),
      .ARRAY_MAX_L (L)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .array_w_l  (array_w_l),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .input_data (input_data),
      .lane_valid (lane_valid),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int e     = 0;

   // Expected output per edge index: what each lane shows right after that edge.
   bit [W-1:0] ed  [MAXC][L];
   bit         evl [MAXC][L];

   bit m_active = 1'b0;
   bit m_ready  = 1'b1;
   int m_w      = 0;
   int m_lastE  = -1;
   bit exp_busy, exp_ready, exp_done, drain;
   logic [0:L-1][W-1:0] exp_data;
   logic [0:L-1]        exp_lv;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic rand_vec();
      for (int j = 0; j < L; j++) in_data[j] = W'($urandom);
   endtask

   task automatic tick();
      @(posedge clk);
      e++;
      if (e >= MAXC - L - 2) begin
         $display("FAIL cycle_budget observed=%0d expected<%0d", e, MAXC - L - 2);
         $fatal(1, "cycle budget exhausted");
      end
      if (!reset_n) begin
         m_active = 1'b0;
         m_lastE  = -1;
         for (int k = e; k < e + L + 2; k++) begin
            for (int j = 0; j < L; j++) begin
               ed[k][j]  = '0;
               evl[k][j] = 1'b0;
            end
         end
      end else if (in_valid && m_ready) begin
         if (!m_active) begin
            m_active = 1'b1;
            m_lastE  = -1;
            m_w      = (int'(array_w_l) > L - 1) ? L - 1 : int'(array_w_l);
         end
         for (int j = 0; j <= m_w; j++) begin
            ed[e+j][j]  = in_data[j];
            evl[e+j][j] = 1'b1;
         end
         if (in_last) begin
            m_active = 1'b0;
            m_lastE  = e;
         end
      end
      drain     = (m_lastE >= 0) && (e >= m_lastE) && (e <= m_lastE + m_w);
      exp_done  = (m_lastE >= 0) && (e == m_lastE + m_w);
      exp_busy  = m_active || drain;
      exp_ready = !drain;
      for (int j = 0; j < L; j++) begin
         exp_data[j] = ed[e][j];
         exp_lv[j]   = evl[e][j];
      end
      #1;
      chk("input_data", 128'(input_data), 128'(exp_data));
      chk("lane_valid", 128'(lane_valid), 128'(exp_lv));
      chk("done",       128'(done),       128'(exp_done));
      chk("busy",       128'(busy),       128'(exp_busy));
      chk("in_ready",   128'(in_ready),   128'(exp_ready));
      m_ready = exp_ready;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int k = 0; k < n; k++) begin
         rand_vec();
         tick();
      end
   endtask

   int len;
   int sent;
   int guard;

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b1;
      in_last   = 1'b0;
      array_w_l = '0;
      rand_vec();

      // reset held with traffic present
      for (int k = 0; k < 4; k++) begin
         rand_vec();
         tick();
      end
      reset_n = 1'b1;
      idle(3);

      // basic skew, w_l = 1
      array_w_l = 4'd1;
      for (int k = 0; k < 5; k++) begin
         rand_vec();
         in_data[0] = W'(2 * k + 1);
         in_data[1] = W'(2 * k + 2);
         in_valid   = 1'b1;
         in_last    = (k == 4);
         tick();
      end
      idle(4);

      // bubble inside a burst, w_l = 2
      array_w_l = 4'd2;
      rand_vec();
      in_data[0] = 8'd1; in_data[1] = 8'd2; in_data[2] = 8'd3;
      in_valid = 1'b1; in_last = 1'b0;
      tick();
      idle(1);
      rand_vec();
      in_data[0] = 8'd4; in_data[1] = 8'd5; in_data[2] = 8'd6;
      in_valid = 1'b1; in_last = 1'b1;
      tick();
      idle(4);

      // full-width single vector, in_valid held through DRAIN
      array_w_l = 4'd9;
      for (int j = 0; j < L; j++) in_data[j] = W'(j + 1);
      in_valid = 1'b1; in_last = 1'b1;
      tick();
      in_last = 1'b0;
      for (int k = 0; k < 10; k++) begin
         rand_vec();
         tick();
      end
      idle(3);

      // clamp 15 -> 9, then width change mid-stream is ignored
      array_w_l = 4'd15;
      for (int k = 0; k < 3; k++) begin
         rand_vec();
         in_valid = 1'b1;
         in_last  = (k == 2);
         tick();
         array_w_l = 4'd0;
      end
      idle(12);

      // single-lane burst
      array_w_l = 4'd0;
      for (int k = 0; k < 3; k++) begin
         rand_vec();
         in_valid = 1'b1;
         in_last  = (k == 2);
         tick();
      end
      idle(3);

      // reset one cycle into DRAIN
      array_w_l = 4'd5;
      rand_vec();
      in_valid = 1'b1; in_last = 1'b1;
      tick();
      idle(1);
      reset_n = 1'b0;
      idle(1);
      reset_n = 1'b1;
      idle(8);

      // random bursts
      for (int b = 0; b < 25; b++) begin
         array_w_l = LW'($urandom_range(0, 15));
         len  = $urandom_range(1, 6);
         sent = 0;
         while (sent < len) begin
            rand_vec();
            in_valid = ($urandom_range(0, 3) != 0);
            in_last  = in_valid ? (sent == len - 1) : 1'($urandom);
            if (in_valid) sent++;
            tick();
            array_w_l = LW'($urandom);
         end
         guard = 0;
         while (exp_busy && guard < 40) begin
            rand_vec();
            in_valid = 1'($urandom);
            in_last  = 1'($urandom);
            tick();
            guard++;
         end
         idle($urandom_range(0, 2));
      end
      idle(12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
